// File: rtl/stage_co_arbiter_pkg.sv
// Shared types for the complete-stage arbiter: the execute-to-complete packet,
// source identifiers and default sizing.
package stage_co_arbiter_pkg;

   localparam int CO_NUM_SRC    = 3;
   localparam int CO_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      CO_SRC_ALU    = 2'd0,
      CO_SRC_MULT   = 2'd1,
      CO_SRC_BRANCH = 2'd2
   } CO_SRC;

   typedef struct packed {
      logic [31:0] result;
      logic [5:0]  dest_tag;
      logic [4:0]  rob_idx;
      logic        take_branch;
      logic [31:0] target_pc;
      logic        halt;
   } EX_CO_PACKET;

   // Next source index, wrapping modulo n
   function automatic int co_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/co_src_fifo.sv
// Single-source circular result FIFO with push/pop, synchronous flush and
// full/empty flags; the head entry is always visible on head_packet.
module co_src_fifo
   import stage_co_arbiter_pkg::*;
#(
   parameter int DEPTH = CO_FIFO_DEPTH
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        push,
   input  EX_CO_PACKET push_packet,
   input  logic        pop,
   output EX_CO_PACKET head_packet,
   output logic        full,
   output logic        empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   EX_CO_PACKET   mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full        = (count_r == FULL_CNT);
   assign empty       = (count_r == CW'(0));
   assign head_packet = mem_r[rd_ptr_r];

   // Qualify requests: a full FIFO refuses pushes, flush overrides both
   always_comb begin
      do_push_s = push & ~full & ~flush;
      do_pop_s  = pop & ~empty & ~flush;
   end

   // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else if (flush) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_packet;
      end
   end

endmodule

// File: rtl/stage_co_arbiter.sv
// Complete-stage arbiter: per-source FIFOs feeding one registered CDB slot.
// Arbitration is round-robin when CO_ROUND_ROBIN_EN is defined, else fixed
// priority BRANCH > MULT > ALU.
module stage_co_arbiter
   import stage_co_arbiter_pkg::*;
#(
   parameter int NUM_SRC = CO_NUM_SRC,
   parameter int DEPTH   = CO_FIFO_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         ex_valid,
   input  EX_CO_PACKET                ex_packet [NUM_SRC],
   output logic [NUM_SRC-1:0]         ex_ready,
   input  logic                       squash,
   input  logic                       cdb_ready,
   output logic                       cdb_valid,
   output EX_CO_PACKET                cdb_packet,
   output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

   localparam int SW = $clog2(NUM_SRC);

   EX_CO_PACKET        head_pkt_s [NUM_SRC];
   logic [NUM_SRC-1:0] full_s;
   logic [NUM_SRC-1:0] empty_s;
   logic [NUM_SRC-1:0] pop_s;
   logic [SW-1:0]      win_s;
   logic               any_s;
   logic               load_s;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      co_src_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clock       (clock),
         .reset       (reset),
         .flush       (squash),
         .push        (ex_valid[gi]),
         .push_packet (ex_packet[gi]),
         .pop         (pop_s[gi]),
         .head_packet (head_pkt_s[gi]),
         .full        (full_s[gi]),
         .empty       (empty_s[gi])
      );
      // Ready depends only on registered occupancy
      assign ex_ready[gi] = ~full_s[gi];
   end

`ifdef CO_ROUND_ROBIN_EN
   logic [SW-1:0] rr_ptr_r;

   // Round-robin pick: search begins one past the last granted source
   always_comb begin
      int cand_s;
      win_s  = SW'(0);
      any_s  = 1'b0;
      cand_s = int'(rr_ptr_r);
      for (int k = 0; k < NUM_SRC; k++) begin
         cand_s = co_wrap_inc(cand_s, NUM_SRC);
         if (!any_s && !empty_s[cand_s]) begin
            win_s = SW'(cand_s);
            any_s = 1'b1;
         end else begin
            win_s = win_s;
            any_s = any_s;
         end
      end
   end

   // Grant pointer moves only when a result is actually popped
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_r <= SW'(NUM_SRC - 1);
      end else if (!squash && load_s && any_s) begin
         rr_ptr_r <= win_s;
      end
   end
`else
   // Fixed priority: the highest non-empty index wins
   always_comb begin
      win_s = SW'(0);
      any_s = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!empty_s[i]) begin
            win_s = SW'(i);
            any_s = 1'b1;
         end else begin
            win_s = win_s;
            any_s = any_s;
         end
      end
   end
`endif

   // Pop the winner whenever the output slot is free or being consumed
   always_comb begin
      load_s = ~cdb_valid | cdb_ready;
      pop_s  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pop_s[i] = load_s & any_s & ~squash & (win_s == SW'(i));
      end
   end

   // CDB output register; holds while the consumer stalls
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb_valid  <= 1'b0;
         cdb_packet <= '0;
         cdb_src    <= SW'(0);
      end else if (squash) begin
         cdb_valid <= 1'b0;
      end else if (load_s) begin
         if (any_s) begin
            cdb_valid  <= 1'b1;
            cdb_packet <= head_pkt_s[win_s];
            cdb_src    <= win_s;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stage_co_arbiter.sv
// Self-checking bench for stage_co_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_stage_co_arbiter;
   import stage_co_arbiter_pkg::*;

   localparam int NS = 3;
   localparam int DP = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [NS-1:0]     ex_valid;
   EX_CO_PACKET       ex_packet [NS];
   logic [NS-1:0]     ex_ready;
   logic              squash;
   logic              cdb_ready;
   logic              cdb_valid;
   EX_CO_PACKET       cdb_packet;
   logic [1:0]        cdb_src;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   EX_CO_PACKET mq [NS][$];
   bit          m_valid;
   EX_CO_PACKET m_pkt;
   int          m_src;
   int          m_last;

   stage_co_arbiter #(.NUM_SRC(NS), .DEPTH(DP)) dut (
      .clock      (clock),
      .reset      (reset),
      .ex_valid   (ex_valid),
      .ex_packet  (ex_packet),
      .ex_ready   (ex_ready),
      .squash     (squash),
      .cdb_ready  (cdb_ready),
      .cdb_valid  (cdb_valid),
      .cdb_packet (cdb_packet),
      .cdb_src    (cdb_src)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic EX_CO_PACKET mk(input logic [31:0] r);
      EX_CO_PACKET p;
      p.result      = r;
      p.dest_tag    = 6'($urandom);
      p.rob_idx     = 5'($urandom);
      p.take_branch = 1'($urandom);
      p.target_pc   = $urandom;
      p.halt        = 1'b0;
      return p;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_valid = 1'b0;
      m_pkt   = '0;
      m_src   = 0;
      m_last  = NS - 1;
   endfunction

   function automatic int model_pick();
`ifdef CO_ROUND_ROBIN_EN
      for (int k = 1; k <= NS; k++) begin
         int c;
         c = (m_last + k) % NS;
         if (mq[c].size() > 0) return c;
      end
`else
      for (int i = NS - 1; i >= 0; i--) begin
         if (mq[i].size() > 0) return i;
      end
`endif
      return -1;
   endfunction

   function automatic logic [NS-1:0] model_ready();
      logic [NS-1:0] r;
      for (int i = 0; i < NS; i++) r[i] = (mq[i].size() < DP);
      return r;
   endfunction

   // One rising edge of the model, using the inputs present before the edge
   function automatic void model_step();
      bit rdy [NS];
      int w;
      for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < DP);
      if (squash) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
         m_valid = 1'b0;
      end else begin
         if (!m_valid || cdb_ready) begin
            w = model_pick();
            if (w >= 0) begin
               m_pkt   = mq[w].pop_front();
               m_src   = w;
               m_valid = 1'b1;
               m_last  = w;
            end else begin
               m_valid = 1'b0;
            end
         end
         for (int i = 0; i < NS; i++)
            if (ex_valid[i] && rdy[i]) mq[i].push_back(ex_packet[i]);
      end
   endfunction

   task automatic cycle();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid  = '0;
      squash    = 1'b0;
      cdb_ready = 1'b1;
      for (int i = 0; i < NS; i++) ex_packet[i] = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset    = 1'b0;
      ex_valid = 3'b111;
      for (int i = 0; i < NS; i++) ex_packet[i] = mk(32'(i + 40));
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: got %b expected 0", cdb_valid);
      end
      tests_run++;
      if (ex_ready !== 3'b111) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 111", ex_ready);
      end
      tests_run++;
      if (cdb_packet !== EX_CO_PACKET'('0) || cdb_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got pkt %h src %0d expected 0/0", cdb_packet, cdb_src);
      end
      @(negedge clock);
      ex_valid = '0;
      reset    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         tests_run++;
         if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: cycle %0d got %b expected 0", k, cdb_valid);
         end
      end
   endtask

   task automatic test_single_push();
      apply_reset();
      ex_valid     = 3'b001;
      ex_packet[0] = mk(32'd13);
      cycle();
      ex_valid = '0;
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL no_bypass: got valid %b expected 0", cdb_valid);
      end
      cycle();
      tests_run++;
      if (cdb_valid !== 1'b1 || cdb_packet.result !== 32'd13 || cdb_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL single_push: got v%b r%0d s%0d expected v1 r13 s0",
                  cdb_valid, cdb_packet.result, cdb_src);
      end
      cycle();
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_drain: got valid %b expected 0", cdb_valid);
      end
   endtask

   task automatic test_simultaneous();
      int exp_src [3];
      int exp_res [3];
`ifdef CO_ROUND_ROBIN_EN
      exp_src = '{0, 1, 2};
      exp_res = '{3, 18, 7};
`else
      exp_src = '{2, 1, 0};
      exp_res = '{7, 18, 3};
`endif
      apply_reset();
      ex_valid     = 3'b111;
      ex_packet[0] = mk(32'd3);
      ex_packet[1] = mk(32'd18);
      ex_packet[2] = mk(32'd7);
      cycle();
      ex_valid = '0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         tests_run++;
         if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_src[k]) ||
             cdb_packet.result !== 32'(exp_res[k])) begin
            tests_failed++;
            $display("FAIL arb_order[%0d]: got v%b s%0d r%0d expected v1 s%0d r%0d",
                     k, cdb_valid, cdb_src, cdb_packet.result, exp_src[k], exp_res[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      cdb_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ex_valid     = 3'b010;
         ex_packet[1] = mk(32'(100 + k));
         cycle();
      end
      ex_valid = '0;
      tests_run++;
      if (ex_ready !== 3'b101) begin
         tests_failed++;
         $display("FAIL bp_full_ready: got %b expected 101", ex_ready);
      end
      cycle();
      tests_run++;
      if (cdb_valid !== 1'b1 || cdb_packet.result !== 32'd100 || cdb_src !== 2'd1) begin
         tests_failed++;
         $display("FAIL bp_hold: got v%b r%0d s%0d expected v1 r100 s1",
                  cdb_valid, cdb_packet.result, cdb_src);
      end
      cdb_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         cycle();
         tests_run++;
         if (cdb_valid !== 1'b1 || cdb_packet.result !== 32'(100 + k) || ex_ready !== 3'b111) begin
            tests_failed++;
            $display("FAIL bp_drain[%0d]: got v%b r%0d rdy%b expected v1 r%0d rdy111",
                     k, cdb_valid, cdb_packet.result, ex_ready, 100 + k);
         end
      end
      cycle();
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_empty: got valid %b expected 0", cdb_valid);
      end
   endtask

   task automatic test_squash();
      apply_reset();
      cdb_ready = 1'b0;
      ex_valid  = 3'b011;
      for (int k = 0; k < 2; k++) begin
         ex_packet[0] = mk(32'(200 + k));
         ex_packet[1] = mk(32'(300 + k));
         cycle();
      end
      squash       = 1'b1;
      cdb_ready    = 1'b1;
      ex_valid     = 3'b001;
      ex_packet[0] = mk(32'd999);
      cycle();
      squash   = 1'b0;
      ex_valid = '0;
      tests_run++;
      if (cdb_valid !== 1'b0 || ex_ready !== 3'b111) begin
         tests_failed++;
         $display("FAIL squash_clear: got v%b rdy%b expected v0 rdy111", cdb_valid, ex_ready);
      end
      for (int k = 0; k < 3; k++) begin
         cycle();
         tests_run++;
         if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL squash_quiet[%0d]: got valid %b expected 0", k, cdb_valid);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      ex_valid     = 3'b001;
      ex_packet[0] = mk(32'd77);
      cycle();
      ex_valid  = '0;
      cdb_ready = 1'b0;
      cycle();
      tests_run++;
      if (cdb_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_pre: got valid %b expected 1", cdb_valid);
      end
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (cdb_valid !== 1'b0 || ex_ready !== 3'b111) begin
         tests_failed++;
         $display("FAIL async_reset: got v%b rdy%b expected v0 rdy111", cdb_valid, ex_ready);
      end
      model_reset();
      @(negedge clock);
      reset        = 1'b1;
      cdb_ready    = 1'b1;
      ex_valid     = 3'b100;
      ex_packet[2] = mk(32'd55);
      cycle();
      ex_valid = '0;
      cycle();
      tests_run++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_packet.result !== 32'd55) begin
         tests_failed++;
         $display("FAIL async_first_push: got v%b s%0d r%0d expected v1 s2 r55",
                  cdb_valid, cdb_src, cdb_packet.result);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         ex_valid  = 3'($urandom_range(0, 7));
         for (int i = 0; i < NS; i++) ex_packet[i] = mk($urandom);
         cdb_ready = ($urandom_range(0, 3) != 0);
         squash    = ($urandom_range(0, 24) == 0);
         cycle();
         tests_run++;
         if (cdb_valid !== m_valid || ex_ready !== model_ready() ||
             (m_valid && (cdb_packet !== m_pkt || cdb_src !== 2'(m_src)))) begin
            tests_failed++;
            $display("FAIL random[%0d]: got v%b s%0d r%h rdy%b expected v%b s%0d r%h rdy%b",
                     n, cdb_valid, cdb_src, cdb_packet.result, ex_ready,
                     m_valid, m_src, m_pkt.result, model_ready());
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_push();
      test_simultaneous();
      test_backpressure();
      test_squash();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
